// File: rtl/plab1_imul_req_queue_pkg.sv
// Shared muldiv request message layout (func|a|b), func codes and pack/unpack helpers.
// Optional build macro PLAB1_IMUL_REQ_SWAP_EN is consumed by plab1_imul_req_queue.
package plab1_imul_req_queue_pkg;

  localparam int FUNC_NBITS = 3;
  localparam int A_NBITS    = 32;
  localparam int B_NBITS    = 32;
  localparam int MSG_NBITS  = FUNC_NBITS + A_NBITS + B_NBITS;

  localparam logic [FUNC_NBITS-1:0] FUNC_MUL  = 3'd0;
  localparam logic [FUNC_NBITS-1:0] FUNC_DIV  = 3'd1;
  localparam logic [FUNC_NBITS-1:0] FUNC_DIVU = 3'd2;
  localparam logic [FUNC_NBITS-1:0] FUNC_REM  = 3'd3;
  localparam logic [FUNC_NBITS-1:0] FUNC_REMU = 3'd4;

  typedef struct packed {
    logic [FUNC_NBITS-1:0] func;
    logic [A_NBITS-1:0]    a;
    logic [B_NBITS-1:0]    b;
  } muldiv_req_t;

  function automatic muldiv_req_t req_unpack(
    input logic [MSG_NBITS-1:0] msg
  );
    return muldiv_req_t'(msg);
  endfunction

  function automatic logic [MSG_NBITS-1:0] req_pack(
    input muldiv_req_t req
  );
    return MSG_NBITS'(req);
  endfunction

endpackage

// File: rtl/plab1_imul_req_swap.sv
// Operand-order unit: for MUL, puts the smaller unsigned operand in b.
// Purely combinational; sits on the queue write path.
module plab1_imul_req_swap
  import plab1_imul_req_queue_pkg::*;
(
  input  logic [MSG_NBITS-1:0] in_msg,
  output logic [MSG_NBITS-1:0] out_msg
);

  muldiv_req_t req_in;
  muldiv_req_t req_out;

  always_comb begin
    req_in  = req_unpack(in_msg);
    req_out = req_in;
    if (req_in.func == FUNC_MUL && req_in.b > req_in.a) begin
      req_out.a = req_in.b;
      req_out.b = req_in.a;
    end
    out_msg = req_pack(req_out);
  end

endmodule

// File: rtl/plab1_imul_req_queue.sv
// Request queue in front of the iterative multiplier; no bypass, no pipe.
// Build macro PLAB1_IMUL_REQ_SWAP_EN enables MUL operand reordering on enqueue.
module plab1_imul_req_queue
  import plab1_imul_req_queue_pkg::*;
#(
  parameter int p_num_entries = 2,
  parameter int p_msg_nbits   = MSG_NBITS
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enq_val,
  output logic                           enq_rdy,
  input  logic [p_msg_nbits-1:0]         enq_msg,
  output logic                           deq_val,
  input  logic                           deq_rdy,
  output logic [p_msg_nbits-1:0]         deq_msg,
  output logic [$clog2(p_num_entries):0] num_free_entries
);

  localparam int AW = $clog2(p_num_entries);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [CW-1:0]          count;
  logic [p_msg_nbits-1:0] mem [p_num_entries];
  logic [p_msg_nbits-1:0] wr_msg;
  logic                   enq_fire;
  logic                   deq_fire;

  assign enq_rdy  = (count != FULL);
  assign deq_val  = (count != '0);
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  assign num_free_entries = FULL - count;
  assign deq_msg          = mem[head];

`ifdef PLAB1_IMUL_REQ_SWAP_EN
  logic [MSG_NBITS-1:0] swap_out;

  plab1_imul_req_swap u_swap (
    .in_msg  (MSG_NBITS'(enq_msg)),
    .out_msg (swap_out)
  );

  assign wr_msg = p_msg_nbits'(swap_out);
`else
  assign wr_msg = enq_msg;
`endif

  // Pointers wrap for free since depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire)
        tail <= tail + 1'b1;
      if (deq_fire)
        head <= head + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire)
      mem[tail] <= wr_msg;
  end

endmodule
